// File: rtl/level_brick_store_pkg.sv
// Shared brick-grid constants, FSM state type and the hit downgrade rule.
// The collision scanner imports the same constants.
package level_brick_store_pkg;

  localparam int COLS    = 10;
  localparam int ROWS    = 8;
  localparam int TYPE_W  = 4;
  localparam int CNT_W   = 7;
  localparam int CELLS   = COLS * ROWS;
  localparam int IDX_W   = 7;
  localparam int COORD_W = 4;
  localparam int PTS_W   = 4;

  localparam logic [TYPE_W-1:0] T_NOBRICK = 4'd0;
  localparam logic [TYPE_W-1:0] T_RED     = 4'd1;
  localparam logic [TYPE_W-1:0] T_BROWN   = 4'd2;
  localparam logic [TYPE_W-1:0] T_SRED    = 4'd3;
  localparam logic [TYPE_W-1:0] T_SBROWN  = 4'd4;
  localparam logic [TYPE_W-1:0] T_STEEL   = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic              effective;
    logic [TYPE_W-1:0] new_type;
    logic [PTS_W-1:0]  pts;
  } hit_result_t;

  // Codes 5..15 fall through to the default: indestructible, no score.
  function automatic hit_result_t downgrade(input logic [TYPE_W-1:0] t);
    hit_result_t r;
    r.effective = 1'b1;
    r.new_type  = t;
    r.pts       = '0;
    case (t)
      T_RED:    begin r.new_type = T_NOBRICK; r.pts = 4'd1; end
      T_BROWN:  begin r.new_type = T_NOBRICK; r.pts = 4'd2; end
      T_SRED:   begin r.new_type = T_RED;     r.pts = 4'd1; end
      T_SBROWN: begin r.new_type = T_BROWN;   r.pts = 4'd1; end
      default:  r.effective = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] cell_idx(input logic [COORD_W-1:0] x,
                                                input logic [COORD_W-1:0] y);
    return IDX_W'(y) * IDX_W'(COLS) + IDX_W'(x);
  endfunction

  function automatic logic in_range(input logic [COORD_W-1:0] x,
                                    input logic [COORD_W-1:0] y);
    return (x < COORD_W'(COLS)) && (y < COORD_W'(ROWS));
  endfunction

endpackage

// File: rtl/level_brick_store_if.sv
// Game/scanner-facing bundle of the brick store: load control, read port, hit port, status.
interface level_brick_store_if;
  import level_brick_store_pkg::*;

  logic                    load_start;
  logic [1:0]              level_sel;
  logic                    load_busy;
  logic                    load_done;
  logic [COORD_W-1:0]      rd_x;
  logic [COORD_W-1:0]      rd_y;
  logic [TYPE_W-1:0]       rd_type;
  logic                    hit_valid;
  logic [COORD_W-1:0]      hit_x;
  logic [COORD_W-1:0]      hit_y;
  logic                    hit_ready;
  logic                    score_valid;
  logic [PTS_W-1:0]        score_pts;
  logic [CNT_W-1:0]        bricks_left;
  logic                    level_clear;

  modport master (
    output load_start, level_sel, rd_x, rd_y, hit_valid, hit_x, hit_y,
    input  load_busy, load_done, rd_type, hit_ready, score_valid, score_pts,
           bricks_left, level_clear
  );

  modport slave (
    input  load_start, level_sel, rd_x, rd_y, hit_valid, hit_x, hit_y,
    output load_busy, load_done, rd_type, hit_ready, score_valid, score_pts,
           bricks_left, level_clear
  );
endinterface

// File: rtl/level_brick_store_pattern_rom.sv
// Combinational level pattern table: (level_sel, x, y) -> brick type for four fixed levels.
module level_pattern_rom
  import level_brick_store_pkg::*;
(
  input  logic [1:0]         level_sel,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [TYPE_W-1:0]  brick_type
);

  // NOTE: every output of an always_comb gets a default first so no path infers a latch.
  always_comb begin
    brick_type = T_NOBRICK;
    case (level_sel)
      2'd0: if (y < 4'd4) brick_type = T_RED;
      2'd1: begin
        if (y == 4'd0)      brick_type = T_BROWN;
        else if (y == 4'd1) brick_type = T_SRED;
        else if (y == 4'd2) brick_type = x[0] ? T_RED : T_SBROWN;
        else if (y == 4'd7 && (x == 4'd0 || x == COORD_W'(COLS - 1)))
          brick_type = T_STEEL;
      end
      2'd2: if (y < 4'd6 && x[0] == y[0]) brick_type = T_RED;
      default: if (x == y) brick_type = T_SBROWN;
    endcase
  end

endmodule

// File: rtl/level_brick_store.sv
// Brick grid owner: level loading, combinational cell reads, read-modify-write hits,
// remaining-brick count, score pulses and level-clear flag.
module level_brick_store
  import level_brick_store_pkg::*;
(
  input logic                clk,
  input logic                reset,
  level_brick_store_if.slave bus
);

  state_t state, state_next;

  logic [CELLS-1:0][TYPE_W-1:0] grid;
  logic [COORD_W-1:0]           cx, cy;
  logic [1:0]                   sel_q;
  logic [COORD_W-1:0]           hit_x_q, hit_y_q;
  logic [CNT_W-1:0]             bricks_left_q;
  logic                         loaded;
  logic                         load_done_q;
  logic                         score_valid_q;
  logic [PTS_W-1:0]             score_pts_q;
  logic                         level_clear_q;

  logic                         start_load, take_hit, last_cell;
  logic [TYPE_W-1:0]            rom_type;
  logic [TYPE_W-1:0]            hit_cell;
  logic                         hit_in_range;
  logic                         hit_apply;
  hit_result_t                  dg;

  level_pattern_rom u_rom (
    .level_sel  (sel_q),
    .x          (cx),
    .y          (cy),
    .brick_type (rom_type)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_load = 1'b0;
    take_hit   = 1'b0;
    last_cell  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.load_start) begin
          start_load = 1'b1;
          state_next = ST_LOAD;
        end else if (bus.hit_valid) begin
          take_hit   = 1'b1;
          state_next = ST_HIT;
        end
      end
      ST_LOAD: begin
        if (cx == COORD_W'(COLS - 1) && cy == COORD_W'(ROWS - 1)) begin
          last_cell  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_HIT:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Read side of the read-modify-write on the latched hit cell.
  always_comb begin
    hit_in_range = in_range(hit_x_q, hit_y_q);
    hit_cell     = hit_in_range ? grid[cell_idx(hit_x_q, hit_y_q)] : T_NOBRICK;
    dg           = downgrade(hit_cell);
    hit_apply    = (state == ST_HIT) && hit_in_range && dg.effective;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the grid is real state, not a RAM; clearing it on reset is required behaviour.
      grid          <= '0;
      cx            <= '0;
      cy            <= '0;
      sel_q         <= '0;
      hit_x_q       <= '0;
      hit_y_q       <= '0;
      bricks_left_q <= '0;
      loaded        <= 1'b0;
      load_done_q   <= 1'b0;
      score_valid_q <= 1'b0;
      score_pts_q   <= '0;
      level_clear_q <= 1'b0;
    end else begin
      load_done_q   <= last_cell;
      score_valid_q <= hit_apply;
      score_pts_q   <= hit_apply ? dg.pts : '0;
      level_clear_q <= loaded && (bricks_left_q == '0);

      if (start_load) begin
        sel_q         <= bus.level_sel;
        cx            <= '0;
        cy            <= '0;
        bricks_left_q <= '0;
        loaded        <= 1'b0;
        level_clear_q <= 1'b0;
      end

      if (take_hit) begin
        hit_x_q <= bus.hit_x;
        hit_y_q <= bus.hit_y;
      end

      if (state == ST_LOAD) begin
        grid[cell_idx(cx, cy)] <= rom_type;
        bricks_left_q <= bricks_left_q + CNT_W'(rom_type != T_NOBRICK);
        if (cx == COORD_W'(COLS - 1)) begin
          cx <= '0;
          cy <= cy + 4'd1;
        end else begin
          cx <= cx + 4'd1;
        end
        if (last_cell) loaded <= 1'b1;
      end

      if (hit_apply) begin
        grid[cell_idx(hit_x_q, hit_y_q)] <= dg.new_type;
        if (dg.new_type == T_NOBRICK && bricks_left_q != '0)
          bricks_left_q <= bricks_left_q - 1'b1;
      end
    end
  end

  assign bus.rd_type     = in_range(bus.rd_x, bus.rd_y) ? grid[cell_idx(bus.rd_x, bus.rd_y)]
                                                        : T_NOBRICK;
  assign bus.load_busy   = (state == ST_LOAD);
  assign bus.load_done   = load_done_q;
  assign bus.hit_ready   = (state == ST_IDLE) && !reset;
  assign bus.score_valid = score_valid_q;
  assign bus.score_pts   = score_pts_q;
  assign bus.bricks_left = bricks_left_q;
  assign bus.level_clear = level_clear_q;

endmodule

// File: tb/tb_level_brick_store.sv
// Directed bench for level_brick_store: loads, hits, boundary cases, level clear, reset abort.
module tb_level_brick_store;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   load_cycles;
  int   ready_seen;
  int   nonzero_cells;

  level_brick_store_if bus ();

  level_brick_store dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_rd(input string tag, input logic [3:0] x, input logic [3:0] y,
                          input logic [31:0] exp);
    bus.rd_x = x;
    bus.rd_y = y;
    #1;
    check(tag, 32'(bus.rd_type), exp);
  endtask

  // Runs the load wait; hit_ready must never be seen high while busy.
  task automatic wait_load(output int cycles);
    cycles     = 0;
    ready_seen = 0;
    while (bus.load_busy && cycles < 200) begin
      if (bus.hit_ready) ready_seen++;
      cycles++;
      tick();
    end
  endtask

  // Returns just after edge N+1 (the cycle where score_valid is expected).
  task automatic do_hit(input logic [3:0] x, input logic [3:0] y);
    int guard;
    guard = 0;
    while (!bus.hit_ready && guard < 20) begin
      guard++;
      tick();
    end
    check("hit_ready_wait", 32'(bus.hit_ready), 1);
    bus.hit_valid = 1'b1;
    bus.hit_x     = x;
    bus.hit_y     = y;
    tick();
    bus.hit_valid = 1'b0;
    check("hit_ready_in_hit", 32'(bus.hit_ready), 0);
    tick();
  endtask

  initial begin
    reset          = 1'b1;
    bus.load_start = 1'b0;
    bus.level_sel  = 2'd0;
    bus.rd_x       = 4'hF;
    bus.rd_y       = 4'hF;
    bus.hit_valid  = 1'b0;
    bus.hit_x      = 4'd0;
    bus.hit_y      = 4'd0;
    tick();
    tick();

    // Reset state
    check("rst_hit_ready",   32'(bus.hit_ready),   0);
    check("rst_load_busy",   32'(bus.load_busy),   0);
    check("rst_load_done",   32'(bus.load_done),   0);
    check("rst_score_valid", 32'(bus.score_valid), 0);
    check("rst_score_pts",   32'(bus.score_pts),   0);
    check("rst_bricks_left", 32'(bus.bricks_left), 0);
    check("rst_level_clear", 32'(bus.level_clear), 0);
    check_rd("rst_rd_00", 4'd0, 4'd0, 0);
    reset = 1'b0;
    tick();
    check("idle_hit_ready", 32'(bus.hit_ready), 1);

    // Level 0 load
    bus.load_start = 1'b1;
    bus.level_sel  = 2'd0;
    tick();
    bus.load_start = 1'b0;
    wait_load(load_cycles);
    check("l0_busy_cycles", 32'(load_cycles), 80);
    check("l0_ready_in_load", 32'(ready_seen), 0);
    check("l0_load_done", 32'(bus.load_done), 1);
    check("l0_bricks", 32'(bus.bricks_left), 40);
    tick();
    check("l0_load_done_pulse", 32'(bus.load_done), 0);
    check_rd("l0_rd_00", 4'd0, 4'd0, 1);
    check_rd("l0_rd_04", 4'd0, 4'd4, 0);
    check_rd("l0_rd_93", 4'd9, 4'd3, 1);
    check_rd("l0_rd_ff", 4'hF, 4'hF, 0);

    // Hit a RED brick
    check_rd("h32_before", 4'd3, 4'd2, 1);
    do_hit(4'd3, 4'd2);
    check_rd("h32_rd", 4'd3, 4'd2, 0);
    check("h32_score_valid", 32'(bus.score_valid), 1);
    check("h32_pts", 32'(bus.score_pts), 1);
    check("h32_bricks", 32'(bus.bricks_left), 39);
    check("h32_ready_back", 32'(bus.hit_ready), 1);
    tick();
    check("h32_score_pulse", 32'(bus.score_valid), 0);

    // Empty cell and out-of-range hits
    do_hit(4'd0, 4'd5);
    check("empty_score_valid", 32'(bus.score_valid), 0);
    check("empty_bricks", 32'(bus.bricks_left), 39);
    check("empty_ready_back", 32'(bus.hit_ready), 1);
    do_hit(4'd12, 4'd3);
    check("oor_score_valid", 32'(bus.score_valid), 0);
    check("oor_bricks", 32'(bus.bricks_left), 39);
    check("oor_ready_back", 32'(bus.hit_ready), 1);

    // Clear the remaining 39 bricks of level 0
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 10; x++) begin
        if (!(x == 3 && y == 2)) begin
          do_hit(4'(x), 4'(y));
          check("clr_score_valid", 32'(bus.score_valid), 1);
          check("clr_pts", 32'(bus.score_pts), 1);
        end
      end
    end
    check("clr_bricks", 32'(bus.bricks_left), 0);
    check("clr_level_clear_n1", 32'(bus.level_clear), 0);
    tick();
    check("clr_level_clear_n2", 32'(bus.level_clear), 1);

    // New load drops level_clear immediately; level 1 has SRED row at y=1
    bus.load_start = 1'b1;
    bus.level_sel  = 2'd1;
    tick();
    bus.load_start = 1'b0;
    check("l1_level_clear_drop", 32'(bus.level_clear), 0);
    check("l1_busy", 32'(bus.load_busy), 1);
    wait_load(load_cycles);
    check("l1_busy_cycles", 32'(load_cycles), 80);
    check("l1_bricks", 32'(bus.bricks_left), 32);
    check_rd("l1_rd_51", 4'd5, 4'd1, 3);
    check_rd("l1_rd_07", 4'd0, 4'd7, 5);

    do_hit(4'd5, 4'd1);
    check_rd("sred1_rd", 4'd5, 4'd1, 1);
    check("sred1_valid", 32'(bus.score_valid), 1);
    check("sred1_pts", 32'(bus.score_pts), 1);
    check("sred1_bricks", 32'(bus.bricks_left), 32);
    do_hit(4'd5, 4'd1);
    check_rd("sred2_rd", 4'd5, 4'd1, 0);
    check("sred2_pts", 32'(bus.score_pts), 1);
    check("sred2_bricks", 32'(bus.bricks_left), 31);
    do_hit(4'd4, 4'd0);
    check("brown_pts", 32'(bus.score_pts), 2);
    check("brown_bricks", 32'(bus.bricks_left), 30);
    do_hit(4'd0, 4'd2);
    check_rd("sbrown_rd", 4'd0, 4'd2, 2);
    check("sbrown_pts", 32'(bus.score_pts), 1);
    check("sbrown_bricks", 32'(bus.bricks_left), 30);
    do_hit(4'd0, 4'd7);
    check_rd("steel_rd", 4'd0, 4'd7, 5);
    check("steel_valid", 32'(bus.score_valid), 0);
    check("steel_bricks", 32'(bus.bricks_left), 30);

    // Hit held off during a level 3 load, accepted right after it
    bus.load_start = 1'b1;
    bus.level_sel  = 2'd3;
    tick();
    bus.load_start = 1'b0;
    bus.hit_valid  = 1'b1;
    bus.hit_x      = 4'd3;
    bus.hit_y      = 4'd3;
    wait_load(load_cycles);
    check("l3_ready_in_load", 32'(ready_seen), 0);
    check("l3_load_done", 32'(bus.load_done), 1);
    check("l3_ready_after", 32'(bus.hit_ready), 1);
    check("l3_bricks", 32'(bus.bricks_left), 8);
    tick();
    bus.hit_valid = 1'b0;
    check("l3_hit_accepted", 32'(bus.hit_ready), 0);
    tick();
    check("l3_score_valid", 32'(bus.score_valid), 1);
    check("l3_pts", 32'(bus.score_pts), 1);
    check_rd("l3_rd_33", 4'd3, 4'd3, 2);
    check("l3_bricks_after", 32'(bus.bricks_left), 8);

    // Reset during LOAD aborts and clears
    bus.load_start = 1'b1;
    bus.level_sel  = 2'd0;
    tick();
    bus.load_start = 1'b0;
    repeat (30) tick();
    check("mid_busy", 32'(bus.load_busy), 1);
    check("mid_bricks", 32'(bus.bricks_left), 30);
    check_rd("mid_rd_92", 4'd9, 4'd2, 1);
    check_rd("mid_rd_03", 4'd0, 4'd3, 0);
    reset = 1'b1;
    tick();
    check("abort_busy", 32'(bus.load_busy), 0);
    check("abort_ready", 32'(bus.hit_ready), 0);
    check("abort_bricks", 32'(bus.bricks_left), 0);
    reset = 1'b0;
    tick();
    nonzero_cells = 0;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 10; x++) begin
        bus.rd_x = 4'(x);
        bus.rd_y = 4'(y);
        #1;
        if (bus.rd_type != 4'd0) nonzero_cells++;
      end
    end
    check("abort_cells", 32'(nonzero_cells), 0);
    check("abort_idle", 32'(bus.load_busy), 0);
    check("abort_level_clear", 32'(bus.level_clear), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
